// File: rtl/kpscan.sv
// kpscan: 4x4 keypad column scanner with row synchronizer and debouncer.
// One key_valid pulse per debounced press; the scan freezes while a key is held.
module kpscan #(
  parameter int SETTLE_CYCLES   = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kpr,
  output logic [3:0] kpc,
  output logic [3:0] kprs,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int MAXC = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ?
                        DEBOUNCE_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(MAXC);
  localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    SETTLE, SAMPLE, DEBOUNCE, HELD, RELEASE
  } state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]  s1;
  logic [3:0]  rowcap, rowcap_n;
  logic [3:0]  kpc_n, kpc_rot, code_n;
  logic        valid_n, held_n;

  // kpc and rowcap always carry exactly one low bit
  function automatic logic [1:0] idx(input logic [3:0] v);
    unique case (1'b1)
      !v[3]:   idx = 2'd0;
      !v[2]:   idx = 2'd1;
      !v[1]:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] keymap(input logic [1:0] c,
                                        input logic [1:0] r);
    case ({c, r})
      4'h0: keymap = 4'h1;
      4'h1: keymap = 4'h4;
      4'h2: keymap = 4'h7;
      4'h3: keymap = 4'hE;
      4'h4: keymap = 4'h2;
      4'h5: keymap = 4'h5;
      4'h6: keymap = 4'h8;
      4'h7: keymap = 4'h0;
      4'h8: keymap = 4'h3;
      4'h9: keymap = 4'h6;
      4'hA: keymap = 4'h9;
      4'hB: keymap = 4'hF;
      4'hC: keymap = 4'hA;
      4'hD: keymap = 4'hB;
      4'hE: keymap = 4'hC;
      default: keymap = 4'hD;
    endcase
  endfunction

  assign kpc_rot = {kpc[0], kpc[3:1]};

  always_comb begin
    state_n  = state;
    cnt_n    = cnt + 1'b1;
    kpc_n    = kpc;
    rowcap_n = rowcap;
    code_n   = key_code;
    valid_n  = 1'b0;
    held_n   = key_held;
    case (state)
      SETTLE: begin
        if (cnt == SET_LAST) begin
          state_n = SAMPLE;
          cnt_n   = '0;
        end
      end
      SAMPLE: begin
        cnt_n = '0;
        if ($onehot(~kprs)) begin
          rowcap_n = kprs;
          state_n  = DEBOUNCE;
        end else begin
          kpc_n   = kpc_rot;
          state_n = SETTLE;
        end
      end
      DEBOUNCE: begin
        if (kprs != rowcap) begin
          state_n = SETTLE;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = HELD;
          cnt_n   = '0;
          code_n  = keymap(idx(kpc), idx(rowcap));
          valid_n = 1'b1;
          held_n  = 1'b1;
        end
      end
      HELD: begin
        cnt_n = '0;
        if (kprs == 4'hF) state_n = RELEASE;
      end
      RELEASE: begin
        if (kprs != 4'hF) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = SETTLE;
          cnt_n   = '0;
          kpc_n   = kpc_rot;
          held_n  = 1'b0;
        end
      end
      default: begin
        state_n = SETTLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= SETTLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= 4'hF;
      kprs      <= 4'hF;
      cnt       <= '0;
      kpc       <= 4'b0111;
      rowcap    <= 4'b0111;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      s1        <= kpr;
      kprs      <= s1;
      cnt       <= cnt_n;
      kpc       <= kpc_n;
      rowcap    <= rowcap_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

endmodule

// File: tb/tb_kpscan.sv
// tb_kpscan: directed keypad stimulus with a scoreboard of expected codes.
// A monitor pops one expected code per key_valid pulse.
module tb_kpscan;

  localparam int S = 4;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] kpr;
  logic [3:0] kpc;
  logic [3:0] kprs;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic       pact = 1'b0;
  logic [3:0] pcol = 4'hF;
  logic [3:0] prow = 4'hF;

  int nvec = 0;
  int nerr = 0;
  logic [3:0] expq[$];

  assign kpr = (pact && kpc == pcol) ? prow : 4'hF;

  kpscan #(.SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .reset(reset),
    .kpr(kpr),
    .kpc(kpc),
    .kprs(kprs),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [3:0] rotn(input int n);
    logic [3:0] v;
    v = 4'b0111;
    for (int i = 0; i < n; i++) v = {v[0], v[3:1]};
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset && key_valid) begin
      nvec++;
      if (expq.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_pulse: got code %0h expected no pulse",
                 key_code);
      end else begin
        logic [3:0] e;
        e = expq.pop_front();
        if (key_code !== e) begin
          nerr++;
          $display("FAIL pulse_code: got %0h expected %0h", key_code, e);
        end
      end
    end
  end

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_kpc"}, kpc, 4'b0111);
    chk({nm, "_kprs"}, kprs, 4'hF);
    chk({nm, "_valid"}, key_valid, 0);
    chk({nm, "_code"}, key_code, 0);
    chk({nm, "_held"}, key_held, 0);
  endtask

  initial begin
    int changes;
    int found;
    logic [3:0] prev;

    // reset and idle scan
    cyc(3);
    chk_reset_vals("reset");
    reset = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      cyc(1);
      chk($sformatf("idle_kpc_%0d", k), kpc,
          rotn(k < 5 ? 0 : ((k - 5) / 5 + 1) % 4));
    end
    chk("idle_held", key_held, 0);

    // steady '5'
    pcol = 4'b1011; prow = 4'b1011;
    expq.push_back(4'h5);
    pact = 1'b1;
    cyc(60);
    chk("k5_pending", expq.size(), 0);
    chk("k5_held", key_held, 1);
    chk("k5_kpc", kpc, 4'b1011);
    chk("k5_code", key_code, 4'h5);
    pact = 1'b0;
    cyc(10);
    chk("k5_rel_held_hi", key_held, 1);
    chk("k5_rel_kpc_hi", kpc, 4'b1011);
    cyc(1);
    chk("k5_rel_held", key_held, 0);
    chk("k5_rel_kpc", kpc, 4'b1101);

    // bouncing 'D'
    pcol = 4'b1110; prow = 4'b1110;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      cyc(1);
      if (kpc == 4'b1110) found = 1;
    end
    chk("kD_col_reached", found, 1);
    expq.push_back(4'hD);
    pact = 1'b1; cyc(5);
    pact = 1'b0; cyc(3);
    pact = 1'b1; cyc(30);
    chk("kD_pending", expq.size(), 0);
    chk("kD_code", key_code, 4'hD);
    chk("kD_held", key_held, 1);
    pact = 1'b0; cyc(4);
    pact = 1'b1; cyc(2);
    pact = 1'b0; cyc(30);
    chk("kD_rel_held", key_held, 0);

    // two rows in one column are ignored
    pcol = 4'b0111; prow = 4'b0011;
    pact = 1'b1;
    cyc(60);
    chk("multi_held", key_held, 0);
    changes = 0;
    prev = kpc;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (kpc != prev) changes++;
      prev = kpc;
    end
    chk("multi_scan_steps", changes, 4);
    pcol = 4'b1101; prow = 4'b1110;
    expq.push_back(4'hF);
    cyc(60);
    chk("kF_pending", expq.size(), 0);
    chk("kF_code", key_code, 4'hF);
    pact = 1'b0;
    cyc(30);

    // long hold '0'
    pcol = 4'b1011; prow = 4'b1110;
    expq.push_back(4'h0);
    pact = 1'b1;
    cyc(1000);
    chk("k0_pending", expq.size(), 0);
    chk("k0_held", key_held, 1);
    chk("k0_code", key_code, 4'h0);
    pact = 1'b0;
    cyc(30);
    chk("k0_rel_held", key_held, 0);
    chk("k0_rel_code", key_code, 4'h0);

    // reset while holding '9'
    pcol = 4'b1101; prow = 4'b1101;
    expq.push_back(4'h9);
    pact = 1'b1;
    cyc(60);
    chk("k9_pending", expq.size(), 0);
    chk("k9_held", key_held, 1);
    chk("k9_code", key_code, 4'h9);
    expq.push_back(4'h9);
    reset = 1'b1;
    cyc(1);
    chk_reset_vals("midreset");
    reset = 1'b0;
    cyc(60);
    chk("k9_redetect_pending", expq.size(), 0);
    chk("k9_redetect_code", key_code, 4'h9);
    chk("k9_redetect_held", key_held, 1);
    pact = 1'b0;
    cyc(30);
    chk("k9_rel_held", key_held, 0);
    chk("final_pending", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
